// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the decode-stage branch controller: compare opcodes,
// FSM state encodings and opcode classification helpers.
package branch_ctrl_pkg;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BGTZ = 3'b001,
    CMP_BLEZ = 3'b010,
    CMP_BNE  = 3'b011,
    CMP_BGEZ = 3'b100,
    CMP_BLTZ = 3'b101,
    CMP_RSVD = 3'b110,
    CMP_NONE = 3'b111
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } br_state_e;

  // The reserved code behaves exactly like "no branch".
  function automatic logic is_branch(input logic [2:0] op);
    return !((op == CMP_NONE) || (op == CMP_RSVD));
  endfunction

  function automatic logic needs_rt(input logic [2:0] op);
    return (op == CMP_BEQ) || (op == CMP_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Combinational branch condition evaluator: (op, rs, rt) -> taken.
// All single-operand compares are signed against zero.
module branch_ctrl_cmp
  import branch_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        taken_o
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_i == 32'd0);
  assign rs_neg  = rs_i[31];

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      CMP_BEQ:  taken_o = (rs_i == rt_i);
      CMP_BNE:  taken_o = (rs_i != rt_i);
      CMP_BGTZ: taken_o = !rs_neg && !rs_zero;
      CMP_BLEZ: taken_o = rs_neg || rs_zero;
      CMP_BGEZ: taken_o = !rs_neg;
      CMP_BLTZ: taken_o = rs_neg;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: waits for forwarded operands, resolves the
// branch, drives PC select/target, link write, optional flush and statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       CMP_Op_D,
  input  logic             Link_D,
  input  logic             RsReady_D,
  input  logic             RtReady_D,
  input  logic [31:0]      RsData_D,
  input  logic [31:0]      RtData_D,
  input  logic [31:0]      PC4_D,
  input  logic [15:0]      Imm16_D,
  input  logic             Hold_D,
  output logic             Stall_D,
  output logic             Taken_D,
  output logic [31:0]      Target_D,
  output logic             Flush_FD,
  output logic             LinkWe_D,
  output logic [31:0]      LinkData_D,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] TakenCount,
  output logic [CNT_W-1:0] StallCount
);

  localparam bit               FLUSH_ON_TAKEN = (DELAY_SLOT == 0);
  localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

  br_state_e        state_q, state_d;
  logic             present;
  logic             ops_ready;
  logic             cmp_taken;
  logic             resolve;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  assign present   = is_branch(CMP_Op_D);
  assign ops_ready = RsReady_D && (!needs_rt(CMP_Op_D) || RtReady_D);

  branch_ctrl_cmp u_cmp (
    .op_i    (CMP_Op_D),
    .rs_i    (RsData_D),
    .rt_i    (RtData_D),
    .taken_o (cmp_taken)
  );

  assign Target_D   = PC4_D + {{14{Imm16_D[15]}}, Imm16_D, 2'b00};
  assign LinkData_D = PC4_D + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    Stall_D  = 1'b0;
    resolve  = 1'b0;
    Flush_FD = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        Stall_D = present && !ops_ready;
        resolve = present && ops_ready && !Hold_D;
        if (!Hold_D) begin
          if (resolve)
            state_d = (cmp_taken && FLUSH_ON_TAKEN) ? ST_FLUSH : ST_IDLE;
          else if (Stall_D)
            state_d = ST_WAIT;
          else
            state_d = ST_IDLE;
        end
      end
      // The instruction now in D sits in the shadow of a taken branch.
      ST_FLUSH: begin
        Flush_FD = 1'b1;
        if (!Hold_D) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Combinational outputs must be quiet while reset is held, even mid-WAIT.
    if (!reset_n) begin
      Stall_D  = 1'b0;
      resolve  = 1'b0;
      Flush_FD = 1'b0;
    end
    Taken_D  = resolve && cmp_taken;
    LinkWe_D = resolve && Link_D;
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    st_cnt_d = st_cnt_q;
    if (resolve && (br_cnt_q != CNT_MAX))
      br_cnt_d = br_cnt_q + CNT_ONE;
    if (Taken_D && (tk_cnt_q != CNT_MAX))
      tk_cnt_d = tk_cnt_q + CNT_ONE;
    if (Stall_D && !Hold_D && (st_cnt_q != CNT_MAX))
      st_cnt_d = st_cnt_q + CNT_ONE;
  end

  assign BrCount    = br_cnt_q;
  assign TakenCount = tk_cnt_q;
  assign StallCount = st_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a delay-slot instance (32-bit counters)
// and a flushing instance (4-bit counters) share the same stimulus.
module tb_branch_ctrl;

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic        link;
    logic        rsr;
    logic        rtr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic        hold;
    logic        e_taken;
    logic        e_stall;
    logic        e_link;
    logic [31:0] e_tgt;
    logic        chk0;
    logic        e_taken0;
    logic        e_flush0;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  op_d;
  logic        link_d, rsr_d, rtr_d, hold_d;
  logic [31:0] rs_d, rt_d, pc4_d;
  logic [15:0] imm_d;

  logic        stall, taken, flush, linkwe;
  logic [31:0] tgt, linkdata;
  logic [31:0] br, tk, st;
  logic        stall0, taken0, flush0, linkwe0;
  logic [31:0] tgt0, linkdata0;
  logic [3:0]  br0, tk0, st0;

  int errs = 0;
  int checks = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  branch_ctrl #(.DELAY_SLOT(1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .CMP_Op_D(op_d), .Link_D(link_d),
    .RsReady_D(rsr_d), .RtReady_D(rtr_d), .RsData_D(rs_d), .RtData_D(rt_d),
    .PC4_D(pc4_d), .Imm16_D(imm_d), .Hold_D(hold_d),
    .Stall_D(stall), .Taken_D(taken), .Target_D(tgt), .Flush_FD(flush),
    .LinkWe_D(linkwe), .LinkData_D(linkdata),
    .BrCount(br), .TakenCount(tk), .StallCount(st)
  );

  branch_ctrl #(.DELAY_SLOT(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .CMP_Op_D(op_d), .Link_D(link_d),
    .RsReady_D(rsr_d), .RtReady_D(rtr_d), .RsData_D(rs_d), .RtData_D(rt_d),
    .PC4_D(pc4_d), .Imm16_D(imm_d), .Hold_D(hold_d),
    .Stall_D(stall0), .Taken_D(taken0), .Target_D(tgt0), .Flush_FD(flush0),
    .LinkWe_D(linkwe0), .LinkData_D(linkdata0),
    .BrCount(br0), .TakenCount(tk0), .StallCount(st0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic [2:0] op,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic rtr, input logic link, input logic hold,
                              input logic [31:0] pc4, input logic [15:0] imm,
                              input logic et, input logic es, input logic el,
                              input logic [31:0] tgt);
    vec_t v;
    v.tag = tag; v.op = op; v.rs = rs; v.rt = rt; v.rsr = 1'b1; v.rtr = rtr;
    v.link = link; v.hold = hold; v.pc4 = pc4; v.imm = imm;
    v.e_taken = et; v.e_stall = es; v.e_link = el; v.e_tgt = tgt;
    v.chk0 = 1'b0; v.e_taken0 = 1'b0; v.e_flush0 = 1'b0;
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mk("idle", 3'b111, 0, 0, 1, 0, 0, 32'h0, 16'h0, 0, 0, 0, 32'h0);
  endfunction

  // Scoreboard consumer: compares whatever was driven this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".taken"},  32'(taken),  32'(e.e_taken));
      chk({e.tag, ".stall"},  32'(stall),  32'(e.e_stall));
      chk({e.tag, ".linkwe"}, 32'(linkwe), 32'(e.e_link));
      chk({e.tag, ".target"}, tgt, e.e_tgt);
      chk({e.tag, ".flush_ds"}, 32'(flush), 32'd0);
      if (e.chk0) begin
        chk({e.tag, ".taken0"}, 32'(taken0), 32'(e.e_taken0));
        chk({e.tag, ".flush0"}, 32'(flush0), 32'(e.e_flush0));
      end
    end
  end

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    op_d = v.op; link_d = v.link; rsr_d = v.rsr; rtr_d = v.rtr;
    rs_d = v.rs; rt_d = v.rt; pc4_d = v.pc4; imm_d = v.imm; hold_d = v.hold;
    exp_q.push_back(v);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    op_d = 3'b111; hold_d = 1'b0; link_d = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    op_d = 3'b111; link_d = 0; rsr_d = 0; rtr_d = 0; hold_d = 0;
    rs_d = 0; rt_d = 0; pc4_d = 0; imm_d = 0;
    #2;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.taken", 32'(taken), 0);
    chk("rst.flush0", 32'(flush0), 0);
    chk("rst.linkwe", 32'(linkwe), 0);
    chk("rst.br", br, 0);
    chk("rst.tk", tk, 0);
    chk("rst.st", st, 0);
    @(negedge clk);
    reset_n = 1'b1;

    tbl.push_back(mk("beq_eq",    3'b000, 5, 5, 1, 0, 0, 32'h1000, 16'h0003, 1, 0, 0, 32'h100C));
    tbl.push_back(mk("beq_ne",    3'b000, 5, 6, 1, 0, 0, 32'h1000, 16'hFFFF, 0, 0, 0, 32'h0FFC));
    tbl.push_back(mk("bne_ne",    3'b011, 5, 6, 1, 0, 0, 32'h2000, 16'h0010, 1, 0, 0, 32'h2040));
    tbl.push_back(mk("bgtz_0",    3'b001, 0, 0, 1, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    tbl.push_back(mk("bgtz_1_nort", 3'b001, 1, 0, 0, 0, 0, 32'h2000, 16'h0, 1, 0, 0, 32'h2000));
    tbl.push_back(mk("bgtz_min",  3'b001, 32'h80000000, 0, 1, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    tbl.push_back(mk("blez_0",    3'b010, 0, 0, 1, 0, 0, 32'h2000, 16'h0, 1, 0, 0, 32'h2000));
    tbl.push_back(mk("blez_min",  3'b010, 32'h80000000, 0, 1, 0, 0, 32'h2000, 16'h0, 1, 0, 0, 32'h2000));
    tbl.push_back(mk("blez_1",    3'b010, 1, 0, 1, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    tbl.push_back(mk("bgez_0",    3'b100, 0, 0, 1, 0, 0, 32'h2000, 16'h0, 1, 0, 0, 32'h2000));
    tbl.push_back(mk("bgez_m1",   3'b100, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    tbl.push_back(mk("bltz_m1",   3'b101, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h2000, 16'h0, 1, 0, 0, 32'h2000));
    tbl.push_back(mk("bltz_0",    3'b101, 0, 0, 1, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    tbl.push_back(mk("none_link", 3'b111, 5, 5, 1, 1, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000));
    v = mk("rsvd_norsr", 3'b110, 5, 5, 0, 0, 0, 32'h2000, 16'h0, 0, 0, 0, 32'h2000);
    v.rsr = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk("bgezal_m1", 3'b100, 32'hFFFFFFFF, 0, 1, 1, 0, 32'h3008, 16'h0, 0, 0, 1, 32'h3008));
    tbl.push_back(mk("beq_wrap",  3'b000, 1, 1, 1, 0, 0, 32'hFFFFFFFC, 16'h0002, 1, 0, 0, 32'h00000004));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    step(idle_v());
    chk("tbl.br", br, 15);
    chk("tbl.tk", tk, 8);
    chk("tbl.st", st, 0);

    // bne waiting three cycles for rt
    do_reset();
    for (int i = 0; i < 3; i++)
      step(mk("bne_wait", 3'b011, 1, 2, 0, 0, 0, 32'h4000, 16'h0001, 0, 1, 0, 32'h4004));
    step(mk("bne_res", 3'b011, 1, 2, 1, 0, 0, 32'h4000, 16'h0001, 1, 0, 0, 32'h4004));
    step(idle_v());
    chk("wait.st", st, 3);
    chk("wait.br", br, 1);
    chk("wait.tk", tk, 1);

    // bgezal not taken still links
    step(mk("bgezal", 3'b100, 32'hFFFFFFFF, 0, 1, 1, 0, 32'h3008, 16'h0, 0, 0, 1, 32'h3008));
    chk("bgezal.linkdata", linkdata, 32'h0000300C);

    // flushing instance: one-cycle flush, shadow branch ignored
    do_reset();
    v = mk("blez_fl", 3'b010, 0, 0, 1, 0, 0, 32'h5000, 16'h0, 1, 0, 0, 32'h5000);
    v.chk0 = 1; v.e_taken0 = 1; v.e_flush0 = 0; step(v);
    v = mk("shadow", 3'b000, 5, 5, 1, 0, 0, 32'h5000, 16'h0, 1, 0, 0, 32'h5000);
    v.chk0 = 1; v.e_taken0 = 0; v.e_flush0 = 1; step(v);
    v = idle_v(); v.tag = "post_fl"; v.chk0 = 1; step(v);
    v = mk("beq_fl", 3'b000, 5, 5, 1, 0, 0, 32'h5000, 16'h0, 1, 0, 0, 32'h5000);
    v.chk0 = 1; v.e_taken0 = 1; v.e_flush0 = 0; step(v);
    v = idle_v(); v.tag = "fl2"; v.chk0 = 1; v.e_flush0 = 1; step(v);
    chk("fl.br0", 32'(br0), 2);
    chk("fl.tk0", 32'(tk0), 2);

    // hold freezes resolution and counters
    do_reset();
    for (int i = 0; i < 2; i++)
      step(mk("hold_bgtz", 3'b001, 1, 0, 1, 1, 1, 32'h6000, 16'h0, 0, 0, 0, 32'h6000));
    step(mk("hold_stall", 3'b011, 1, 2, 0, 0, 1, 32'h6000, 16'h0, 0, 1, 0, 32'h6000));
    chk("hold.br", br, 0);
    step(mk("rel_bgtz", 3'b001, 1, 0, 1, 1, 0, 32'h6000, 16'h0, 1, 0, 1, 32'h6000));
    step(idle_v());
    chk("hold.br1", br, 1);
    chk("hold.tk1", tk, 1);
    chk("hold.st", st, 0);

    // reset in the middle of WAIT
    do_reset();
    for (int i = 0; i < 2; i++)
      step(mk("pre_rst", 3'b011, 1, 2, 0, 0, 0, 32'h7000, 16'h0, 0, 1, 0, 32'h7000));
    chk("pre_rst.st", st, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst.stall", 32'(stall), 0);
    chk("midrst.st", st, 0);
    chk("midrst.br", br, 0);
    op_d = 3'b111;
    #1;
    reset_n = 1'b1;
    step(idle_v());
    chk("postrst.br", br, 0);

    // saturation of the 4-bit counters
    do_reset();
    for (int i = 0; i < 17; i++)
      step(mk("sat", 3'b000, 1, 2, 1, 0, 0, 32'h8000, 16'h0, 0, 0, 0, 32'h8000));
    step(idle_v());
    chk("sat.br0", 32'(br0), 15);
    chk("sat.tk0", 32'(tk0), 0);
    chk("sat.br", br, 17);

    @(negedge clk);
    chk("sb.drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
